// File: rtl/adc_comp_pkg.sv
// Shared constants and FSM state type for the ADC hysteresis threshold detector.
package adc_comp_pkg;

    localparam int          ADC_W_DEF      = 12;
    localparam logic [11:0] THRESH_MID     = 12'h800;
    localparam int          PERIOD_DEF     = 200;
    localparam int          AVG_LOG2_DEF   = 2;
    localparam int          DEGLITCH_N_DEF = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } cmp_state_e;

endpackage

// File: rtl/adc_hyst_comp_if.sv
// Sample/threshold/result bundle between the ADC source (master) and the detector (slave).
interface adc_hyst_comp_if #(
    parameter int ADC_W = adc_comp_pkg::ADC_W_DEF
);
    logic             swiptAlive;
    logic [ADC_W-1:0] ADC;
    logic [ADC_W-1:0] thresh;
    logic [ADC_W-1:0] hyst;
    logic [ADC_W-1:0] avg_out;
    logic             avg_valid;
    logic             ADC_comp;
    logic             comp_valid;
    logic             comp_edge;

    modport master (
        output swiptAlive, ADC, thresh, hyst,
        input  avg_out, avg_valid, ADC_comp, comp_valid, comp_edge
    );

    modport slave (
        input  swiptAlive, ADC, thresh, hyst,
        output avg_out, avg_valid, ADC_comp, comp_valid, comp_edge
    );
endinterface

// File: rtl/adc_avg_accum.sv
// Decimating sample strobe plus box-car accumulator; emits one truncated average per
// window of 2^AVG_LOG2 strobed samples.
module adc_avg_accum #(
    parameter int ADC_W    = 12,
    parameter int PERIOD   = 200,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [ADC_W-1:0] i_adc,
    output logic [ADC_W-1:0] o_avg_out,
    output logic             o_avg_valid
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);
    localparam logic [SMP_W-1:0] SMP_LAST   = SMP_W'((1 << AVG_LOG2) - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [SMP_W-1:0] r_smp;
    logic [ACC_W-1:0] r_acc;
    logic [ADC_W-1:0] r_avg_out;
    logic             r_avg_valid;

    logic             w_clr;
    logic             w_strobe;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;

    assign w_clr    = rst | i_clr;
    assign w_strobe = (r_cnt == {CNT_W{1'b0}});
    assign w_last   = (r_smp == SMP_LAST);
    // The window sum can never exceed ACC_W bits, so no saturation is needed.
    assign w_sum    = r_acc + ACC_W'(i_adc);

    // Decimation counter: strobe on zero, then reload.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cnt <= CNT_RELOAD;
        end else if (w_strobe) begin
            r_cnt <= CNT_RELOAD;
        end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Window accumulation and average publication.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_acc       <= {ACC_W{1'b0}};
            r_smp       <= {SMP_W{1'b0}};
            r_avg_out   <= {ADC_W{1'b0}};
            r_avg_valid <= 1'b0;
        end else if (w_strobe && w_last) begin
            r_acc       <= {ACC_W{1'b0}};
            r_smp       <= {SMP_W{1'b0}};
            r_avg_out   <= w_sum[ACC_W-1:AVG_LOG2];
            r_avg_valid <= 1'b1;
        end else if (w_strobe) begin
            r_acc       <= w_sum;
            r_smp       <= r_smp + {{(SMP_W-1){1'b0}}, 1'b1};
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
        end
    end

    assign o_avg_out   = r_avg_out;
    assign o_avg_valid = r_avg_valid;
endmodule

// File: rtl/adc_hyst_comp.sv
// ADC threshold detector: averaged sample compared against thresh with a symmetric
// hysteresis band. Optional macro ADC_COMP_DEGLITCH_EN adds a consecutive-agreement filter.
module adc_hyst_comp
    import adc_comp_pkg::*;
#(
    parameter int ADC_W      = ADC_W_DEF,
    parameter int PERIOD     = PERIOD_DEF,
    parameter int AVG_LOG2   = AVG_LOG2_DEF,
    parameter int DEGLITCH_N = DEGLITCH_N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    adc_hyst_comp_if.slave  bus
);
    cmp_state_e       r_state;
    cmp_state_e       w_state_nxt;
    logic             w_do_cmp;
    logic             w_clr;
    logic [ADC_W-1:0] w_avg_out;
    logic             w_avg_valid;
    logic [ADC_W-1:0] w_lo;
    logic [ADC_W:0]   w_hi;
    logic             w_req;
    logic             w_flip;
    logic             r_comp;
    logic             r_comp_valid;
    logic             r_comp_edge;

    assign w_clr = rst | ~bus.swiptAlive;

    adc_avg_accum #(
        .ADC_W    (ADC_W),
        .PERIOD   (PERIOD),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (~bus.swiptAlive),
        .i_adc       (bus.ADC),
        .o_avg_out   (w_avg_out),
        .o_avg_valid (w_avg_valid)
    );

    // Compare FSM state register.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; the compare is evaluated while avg_valid is high and lands in CMP.
    always_comb begin
        w_state_nxt = r_state;
        w_do_cmp    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_avg_valid) begin
                    w_state_nxt = CMP;
                    w_do_cmp    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CMP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Band edges: lo clamps at zero, hi carries an extra bit so it never wraps.
    always_comb begin
        w_hi = {1'b0, bus.thresh} + {1'b0, bus.hyst};
        if (bus.thresh >= bus.hyst) begin
            w_lo = bus.thresh - bus.hyst;
        end else begin
            w_lo = {ADC_W{1'b0}};
        end
        if (r_comp) begin
            w_req = ({1'b0, w_avg_out} >= w_hi);
        end else begin
            w_req = (w_avg_out < w_lo);
        end
    end

`ifdef ADC_COMP_DEGLITCH_EN
    localparam int AG_W = $clog2(DEGLITCH_N + 1);
    localparam logic [AG_W-1:0] AGREE_LAST = AG_W'(DEGLITCH_N - 1);
    logic [AG_W-1:0] r_agree;

    assign w_flip = w_do_cmp & w_req & (r_agree == AGREE_LAST);

    // Consecutive flip-request counter; any non-requesting compare or a flip restarts it.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_agree <= {AG_W{1'b0}};
        end else if (w_do_cmp && w_req && !w_flip) begin
            r_agree <= r_agree + {{(AG_W-1){1'b0}}, 1'b1};
        end else if (w_do_cmp) begin
            r_agree <= {AG_W{1'b0}};
        end else begin
            r_agree <= r_agree;
        end
    end
`else
    assign w_flip = w_do_cmp & w_req;
`endif

    // Registered decision outputs.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_comp       <= 1'b0;
            r_comp_valid <= 1'b0;
            r_comp_edge  <= 1'b0;
        end else begin
            r_comp_valid <= w_do_cmp;
            r_comp_edge  <= w_flip;
            r_comp       <= r_comp ^ w_flip;
        end
    end

    assign bus.avg_out    = w_avg_out;
    assign bus.avg_valid  = w_avg_valid;
    assign bus.ADC_comp   = r_comp;
    assign bus.comp_valid = r_comp_valid;
    assign bus.comp_edge  = r_comp_edge;
endmodule
